// File: rtl/escape_parser_if.sv
// Escape parser byte/command bundle: received-byte input plus command and character outputs.
// Latency: none, wiring only; the parser registers every output.
// Backpressure: none; bytes arrive at most one per cycle and every strobe is a one-cycle pulse.
//
// Signals:
//   dataReady    byte valid strobe from the UART receiver
//   data         received byte
//   commandReady one-cycle pulse, complete recognised sequence parsed
//   commandType  decoded command (1 CUP, 2 ED, 3 EL, 4-7 cursor moves when enabled)
//   Pn1, Pn2     decoded parameters with defaults applied
//   charReady    one-cycle pulse, plain character available
//   charData     plain character byte, held until the next charReady
// Modports: master drives bytes and observes outputs; slave is the parser.

interface escape_parser_if;
    logic       dataReady;
    logic [7:0] data;
    logic       commandReady;
    logic [2:0] commandType;
    logic [7:0] Pn1;
    logic [7:0] Pn2;
    logic       charReady;
    logic [7:0] charData;

    modport master (
        output dataReady,
        output data,
        input  commandReady,
        input  commandType,
        input  Pn1,
        input  Pn2,
        input  charReady,
        input  charData
    );

    modport slave (
        input  dataReady,
        input  data,
        output commandReady,
        output commandType,
        output Pn1,
        output Pn2,
        output charReady,
        output charData
    );
endinterface

// File: rtl/escape_parser.sv
// VT100/ANSI escape parser: splits the console byte stream into plain characters and CSI commands.
// Latency: one cycle from a sampled byte to its charReady or commandReady pulse (registered outputs).
// Backpressure: none; one byte per cycle is always accepted and cycles with dataReady low change nothing.
//
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  asynchronous active-low reset
//   bus  escape_parser_if.slave (dataReady/data in; commandReady/commandType/Pn1/Pn2/charReady/charData out)
//
// Build option: define ESC_CURSOR_MOVE_EN to decode the final bytes 'A'..'D' as cursor moves
// (types 4-7, default parameter 1). Left undefined, those bytes abort the sequence like any
// other unknown final byte.

module escape_parser (
    input  logic            clk,
    input  logic            rst,
    escape_parser_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ESC      = 3'd1,
        S_CSI_P1   = 3'd2,
        S_CSI_P2   = 3'd3,
        S_CSI_SKIP = 3'd4
    } state_t;

    localparam logic [7:0] C_ESC  = 8'h1B;
    localparam logic [7:0] C_CAN  = 8'h18;
    localparam logic [7:0] C_SUB  = 8'h1A;
    localparam logic [7:0] C_LBR  = 8'h5B;
    localparam logic [7:0] C_SEMI = 8'h3B;
    localparam logic [7:0] C_D0   = 8'h30;
    localparam logic [7:0] C_D9   = 8'h39;

    localparam logic [2:0] T_CUP = 3'd1;
    localparam logic [2:0] T_ED  = 3'd2;
    localparam logic [2:0] T_EL  = 3'd3;
`ifdef ESC_CURSOR_MOVE_EN
    localparam logic [2:0] T_CUU = 3'd4;
    localparam logic [2:0] T_CUD = 3'd5;
    localparam logic [2:0] T_CUF = 3'd6;
    localparam logic [2:0] T_CUB = 3'd7;
`endif

    state_t     state;
    logic [7:0] acc1;
    logic [7:0] acc2;
    logic       seen1;
    logic       seen2;

    logic       cmd_rdy_q;
    logic [2:0] cmd_type_q;
    logic [7:0] pn1_q;
    logic [7:0] pn2_q;
    logic       chr_rdy_q;
    logic [7:0] chr_dat_q;

    // Decimal accumulate at 12 bits (255*10+9 fits), then clamp so large
    // parameters stick at 255 instead of wrapping.
    function automatic logic [7:0] acc_step(input logic [7:0] acc, input logic [3:0] digit);
        logic [11:0] wide;
        wide = ({4'd0, acc} * 12'd10) + {8'd0, digit};
        return (wide > 12'd255) ? 8'hFF : wide[7:0];
    endfunction

    logic       is_digit;
    logic       is_abort;
    logic       fin_vld;
    logic [2:0] fin_type;
    logic [7:0] acc1_next;
    logic [7:0] acc2_next;
    logic [7:0] p1_dflt1;
    logic [7:0] p1_dflt0;
    logic [7:0] p2_dflt1;
    logic [7:0] cmd_p1;
    logic [7:0] cmd_p2;

    assign is_digit  = (bus.data >= C_D0) && (bus.data <= C_D9);
    assign is_abort  = (bus.data == C_CAN) || (bus.data == C_SUB);
    assign acc1_next = acc_step(acc1, bus.data[3:0]);
    assign acc2_next = acc_step(acc2, bus.data[3:0]);

    // Final-byte decode; fin_vld low means the byte ends the sequence without a command.
    always_comb begin
        fin_vld  = 1'b0;
        fin_type = 3'd0;
        case (bus.data)
            8'h48, 8'h66: begin fin_vld = 1'b1; fin_type = T_CUP; end  // 'H', 'f'
            8'h4A:        begin fin_vld = 1'b1; fin_type = T_ED;  end  // 'J'
            8'h4B:        begin fin_vld = 1'b1; fin_type = T_EL;  end  // 'K'
`ifdef ESC_CURSOR_MOVE_EN
            8'h41:        begin fin_vld = 1'b1; fin_type = T_CUU; end  // 'A'
            8'h42:        begin fin_vld = 1'b1; fin_type = T_CUD; end  // 'B'
            8'h43:        begin fin_vld = 1'b1; fin_type = T_CUF; end  // 'C'
            8'h44:        begin fin_vld = 1'b1; fin_type = T_CUB; end  // 'D'
`endif
            default: begin fin_vld = 1'b0; fin_type = 3'd0; end
        endcase
    end

    // Parameter defaults. Positioning commands treat absent and zero alike
    // (both mean 1); erase commands treat an absent parameter as 0.
    // Pn2 only carries information for CUP.
    always_comb begin
        p1_dflt1 = (!seen1 || (acc1 == 8'd0)) ? 8'd1 : acc1;
        p1_dflt0 = seen1 ? acc1 : 8'd0;
        p2_dflt1 = (!seen2 || (acc2 == 8'd0)) ? 8'd1 : acc2;
        cmd_p1   = ((fin_type == T_ED) || (fin_type == T_EL)) ? p1_dflt0 : p1_dflt1;
        cmd_p2   = (fin_type == T_CUP) ? p2_dflt1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            acc1       <= 8'd0;
            acc2       <= 8'd0;
            seen1      <= 1'b0;
            seen2      <= 1'b0;
            cmd_rdy_q  <= 1'b0;
            cmd_type_q <= 3'd0;
            pn1_q      <= 8'd0;
            pn2_q      <= 8'd0;
            chr_rdy_q  <= 1'b0;
            chr_dat_q  <= 8'd0;
        end else begin
            // Strobes are single-cycle; only a sampled byte can raise one.
            cmd_rdy_q <= 1'b0;
            chr_rdy_q <= 1'b0;
            if (bus.dataReady) begin
                case (state)
                    S_IDLE: begin
                        if (bus.data == C_ESC) begin
                            state <= S_ESC;
                        end else begin
                            chr_rdy_q <= 1'b1;
                            chr_dat_q <= bus.data;
                        end
                    end

                    S_ESC: begin
                        if (bus.data == C_LBR) begin
                            state <= S_CSI_P1;
                            acc1  <= 8'd0;
                            acc2  <= 8'd0;
                            seen1 <= 1'b0;
                            seen2 <= 1'b0;
                        end else if (bus.data == C_ESC) begin
                            state <= S_ESC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end

                    S_CSI_P1, S_CSI_P2, S_CSI_SKIP: begin
                        if (is_digit) begin
                            // Digits past the second parameter fall through untouched.
                            if (state == S_CSI_P1) begin
                                acc1  <= acc1_next;
                                seen1 <= 1'b1;
                            end else if (state == S_CSI_P2) begin
                                acc2  <= acc2_next;
                                seen2 <= 1'b1;
                            end
                        end else if (bus.data == C_SEMI) begin
                            if (state == S_CSI_P1) begin
                                state <= S_CSI_P2;
                            end else begin
                                state <= S_CSI_SKIP;
                            end
                        end else if (bus.data == C_ESC) begin
                            // A fresh ESC restarts rather than aborts to IDLE.
                            state <= S_ESC;
                        end else if (is_abort) begin
                            state <= S_IDLE;
                        end else if (fin_vld) begin
                            state      <= S_IDLE;
                            cmd_rdy_q  <= 1'b1;
                            cmd_type_q <= fin_type;
                            pn1_q      <= cmd_p1;
                            pn2_q      <= cmd_p2;
                        end else begin
                            // Unknown byte: sequence is discarded, byte is not echoed.
                            state <= S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.commandReady = cmd_rdy_q;
    assign bus.commandType  = cmd_type_q;
    assign bus.Pn1          = pn1_q;
    assign bus.Pn2          = pn2_q;
    assign bus.charReady    = chr_rdy_q;
    assign bus.charData     = chr_dat_q;

endmodule

// File: tb/tb_escape_parser.sv
// Testbench for escape_parser: directed vector table, hand-written timing/reset sequences,
// and a randomized byte stream checked against a string-splitting reference model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.

module tb_escape_parser;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    escape_parser_if bus ();

    escape_parser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive a byte (or idle) on the falling edge, sample just after the rising edge.
    task automatic step(input logic vld, input logic [7:0] d);
        @(negedge clk);
        bus.dataReady = vld;
        bus.data      = d;
        @(posedge clk);
        #1;
        chk("strobe_exclusive", {31'd0, bus.commandReady & bus.charReady}, 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string seq;
        int    ncmd;
        int    nchr;
        int    typ;
        int    p1;
        int    p2;
        int    ch;
    } vec_t;

    function automatic vec_t mk(input string s, input int nc, input int nh,
                                input int t, input int a, input int b, input int c);
        vec_t v;
        v.seq  = s;
        v.ncmd = nc;
        v.nchr = nh;
        v.typ  = t;
        v.p1   = a;
        v.p2   = b;
        v.ch   = c;
        return v;
    endfunction

    vec_t tbl[$];

    // ---------------- reference model ----------------
    // Mode 0 text, 1 after ESC, 2 inside a CSI body whose bytes are collected as text.
    int          m_mode;
    byte         m_buf[$];
    logic        m_cmd;
    logic        m_chr;
    logic [2:0]  m_type;
    logic [7:0]  m_p1;
    logic [7:0]  m_p2;
    logic [7:0]  m_char;

    function automatic int final_type(input logic [7:0] b);
        case (b)
            "H", "f": return 1;
            "J":      return 2;
            "K":      return 3;
`ifdef ESC_CURSOR_MOVE_EN
            "A":      return 4;
            "B":      return 5;
            "C":      return 6;
            "D":      return 7;
`endif
            default:  return 0;
        endcase
    endfunction

    // Split the collected body on ';' and evaluate the first two decimal fields, clamped to 255.
    function automatic void eval_params(output int v1, output int v2);
        int vals[2];
        int idx;
        int cur;
        vals[0] = 0;
        vals[1] = 0;
        idx = 0;
        cur = 0;
        foreach (m_buf[i]) begin
            if (m_buf[i] == ";") begin
                if (idx < 2) vals[idx] = (cur > 255) ? 255 : cur;
                idx++;
                cur = 0;
            end else begin
                cur = (cur > 100000) ? cur : cur * 10 + (int'(m_buf[i]) - 48);
            end
        end
        if (idx < 2) vals[idx] = (cur > 255) ? 255 : cur;
        v1 = vals[0];
        v2 = vals[1];
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_buf.delete();
        m_cmd  = 1'b0;
        m_chr  = 1'b0;
        m_type = 3'd0;
        m_p1   = 8'd0;
        m_p2   = 8'd0;
        m_char = 8'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int t;
        int v1;
        int v2;
        m_cmd = 1'b0;
        m_chr = 1'b0;
        if (m_mode == 0) begin
            if (b == 8'h1B) m_mode = 1;
            else begin
                m_chr  = 1'b1;
                m_char = b;
            end
        end else if (m_mode == 1) begin
            if (b == "[") begin
                m_mode = 2;
                m_buf.delete();
            end else if (b != 8'h1B) begin
                m_mode = 0;
            end
        end else begin
            t = final_type(b);
            if ((b >= "0" && b <= "9") || b == ";") begin
                m_buf.push_back(byte'(b));
            end else if (b == 8'h1B) begin
                m_mode = 1;
            end else if (t != 0) begin
                eval_params(v1, v2);
                m_cmd  = 1'b1;
                m_type = 3'(t);
                if (t == 2 || t == 3) begin
                    m_p1 = 8'(v1);
                    m_p2 = 8'd0;
                end else begin
                    m_p1 = (v1 == 0) ? 8'd1 : 8'(v1);
                    m_p2 = (t == 1) ? ((v2 == 0) ? 8'd1 : 8'(v2)) : 8'd0;
                end
                m_mode = 0;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 19);
        if (r <= 2)       return 8'h1B;
        else if (r <= 4)  return "[";
        else if (r <= 9)  return 8'($urandom_range(48, 57));
        else if (r <= 11) return ";";
        else if (r == 12) return "H";
        else if (r == 13) return "f";
        else if (r == 14) return "J";
        else if (r == 15) return "K";
        else if (r == 16) return 8'(65 + $urandom_range(0, 3));
        else if (r == 17) return ($urandom_range(0, 1) == 0) ? 8'h18 : 8'h1A;
        else              return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        int ncmd;
        int nchr;
        logic [2:0] l_type;
        logic [7:0] l_p1;
        logic [7:0] l_p2;
        logic [7:0] l_ch;
        string s;
        logic vld;
        logic [7:0] b;

        // "\033" = ESC, "\030" = CAN, "\032" = SUB
        tbl.push_back(mk("AB",                  0, 2, 0,   0, 0,  8'h42));
        tbl.push_back(mk("\033[12;34H",         1, 0, 1,  12, 34, 0));
        tbl.push_back(mk("\033[H",              1, 0, 1,   1, 1,  0));
        tbl.push_back(mk("\033[0;0f",           1, 0, 1,   1, 1,  0));
        tbl.push_back(mk("\033[999;5;7H",       1, 0, 1, 255, 5,  0));
        tbl.push_back(mk("\033[2J",             1, 0, 2,   2, 0,  0));
        tbl.push_back(mk("\033[K",              1, 0, 3,   0, 0,  0));
        tbl.push_back(mk("\033[3\030x",         0, 1, 0,   0, 0,  8'h78));
`ifdef ESC_CURSOR_MOVE_EN
        tbl.push_back(mk("\033[5A",             1, 0, 4,   5, 0,  0));
        tbl.push_back(mk("\033[D",              1, 0, 7,   1, 0,  0));
`else
        tbl.push_back(mk("\033[5A",             0, 0, 0,   0, 0,  0));
        tbl.push_back(mk("\033[Dq",             0, 1, 0,   0, 0,  8'h71));
`endif
        tbl.push_back(mk("\033[;7H",            1, 0, 1,   1, 7,  0));
        tbl.push_back(mk("\033[12;34\033[3;4H", 1, 0, 1,   3, 4,  0));
        tbl.push_back(mk("\033\033[7K",         1, 0, 3,   7, 0,  0));
        tbl.push_back(mk("\033xy",              0, 1, 0,   0, 0,  8'h79));
        tbl.push_back(mk("\033[5Zq",            0, 1, 0,   0, 0,  8'h71));
        tbl.push_back(mk("\033[256J",           1, 0, 2, 255, 0,  0));
        tbl.push_back(mk("\033[3;\032Z",        0, 1, 0,   0, 0,  8'h5A));
        tbl.push_back(mk("\033[0K",             1, 0, 3,   0, 0,  0));

        // ---------------- reset state ----------------
        rst           = 1'b0;
        bus.dataReady = 1'b0;
        bus.data      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_commandReady", {31'd0, bus.commandReady}, 32'd0);
        chk("rst_commandType",  {29'd0, bus.commandType},  32'd0);
        chk("rst_Pn1",          {24'd0, bus.Pn1},          32'd0);
        chk("rst_Pn2",          {24'd0, bus.Pn2},          32'd0);
        chk("rst_charReady",    {31'd0, bus.charReady},    32'd0);
        chk("rst_charData",     {24'd0, bus.charData},     32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- table-driven vectors ----------------
        foreach (tbl[k]) begin
            s      = tbl[k].seq;
            ncmd   = 0;
            nchr   = 0;
            l_type = 3'd0;
            l_p1   = 8'd0;
            l_p2   = 8'd0;
            l_ch   = 8'd0;
            for (int i = 0; i < s.len(); i++) begin
                step(1'b1, s[i]);
                if (bus.commandReady) begin
                    ncmd++;
                    l_type = bus.commandType;
                    l_p1   = bus.Pn1;
                    l_p2   = bus.Pn2;
                end
                if (bus.charReady) begin
                    nchr++;
                    l_ch = bus.charData;
                end
            end
            step(1'b0, 8'h00);
            if (bus.commandReady || bus.charReady) ncmd += 100;
            chk($sformatf("vec%0d_ncmd", k), 32'(ncmd), 32'(tbl[k].ncmd));
            chk($sformatf("vec%0d_nchr", k), 32'(nchr), 32'(tbl[k].nchr));
            if (tbl[k].ncmd > 0) begin
                chk($sformatf("vec%0d_type", k), {29'd0, l_type}, 32'(tbl[k].typ));
                chk($sformatf("vec%0d_Pn1", k),  {24'd0, l_p1},   32'(tbl[k].p1));
                chk($sformatf("vec%0d_Pn2", k),  {24'd0, l_p2},   32'(tbl[k].p2));
            end
            if (tbl[k].nchr > 0) begin
                chk($sformatf("vec%0d_char", k), {24'd0, l_ch}, 32'(tbl[k].ch));
            end
        end

        // ---------------- final byte then plain character, back to back ----------------
        step(1'b1, 8'h1B);
        step(1'b1, "[");
        step(1'b1, "2");
        step(1'b1, "J");
        chk("b2b_cmd_n1",  {31'd0, bus.commandReady}, 32'd1);
        chk("b2b_chr_n1",  {31'd0, bus.charReady},    32'd0);
        chk("b2b_type",    {29'd0, bus.commandType},  32'd2);
        step(1'b1, "z");
        chk("b2b_cmd_n2",  {31'd0, bus.commandReady}, 32'd0);
        chk("b2b_chr_n2",  {31'd0, bus.charReady},    32'd1);
        chk("b2b_char",    {24'd0, bus.charData},     32'h7A);
        step(1'b0, 8'h00);
        chk("b2b_chr_n3",  {31'd0, bus.charReady},    32'd0);
        chk("b2b_hold_t",  {29'd0, bus.commandType},  32'd2);
        chk("b2b_hold_ch", {24'd0, bus.charData},     32'h7A);

        // ---------------- asynchronous reset clears a pending strobe ----------------
        step(1'b1, 8'h1B);
        step(1'b1, "[");
        step(1'b1, "6");
        step(1'b1, "J");
        chk("pre_rst_cmd", {31'd0, bus.commandReady}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_cmd",  {31'd0, bus.commandReady}, 32'd0);
        chk("arst_type", {29'd0, bus.commandType},  32'd0);
        chk("arst_Pn1",  {24'd0, bus.Pn1},          32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- reset mid-sequence discards it ----------------
        step(1'b1, 8'h1B);
        step(1'b1, "[");
        step(1'b1, "4");
        rst = 1'b0;
        #2;
        rst = 1'b1;
        ncmd = 0;
        nchr = 0;
        l_ch = 8'd0;
        s = ";2H";
        for (int i = 0; i < s.len(); i++) begin
            step(1'b1, s[i]);
            if (bus.commandReady) ncmd++;
            if (bus.charReady) begin
                nchr++;
                l_ch = bus.charData;
            end
        end
        chk("midrst_ncmd", 32'(ncmd), 32'd0);
        chk("midrst_nchr", 32'(nchr), 32'd3);
        chk("midrst_char", {24'd0, l_ch}, 32'h48);

        // ---------------- randomized stream against the reference model ----------------
        step(1'b0, 8'h00);
        rst = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            vld = ($urandom_range(0, 4) != 0);
            b   = rand_byte();
            if (vld) model_byte(b);
            else begin
                m_cmd = 1'b0;
                m_chr = 1'b0;
            end
            step(vld, b);
            chk("rnd_strobes", {30'd0, bus.commandReady, bus.charReady}, {30'd0, m_cmd, m_chr});
            chk("rnd_cmd_hold", {13'd0, bus.commandType, bus.Pn1, bus.Pn2}, {13'd0, m_type, m_p1, m_p2});
            chk("rnd_charData", {24'd0, bus.charData}, {24'd0, m_char});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
